// File: rtl/eth_rx_parser_if.sv
// Byte-stream bundle between the receive PHY side and eth_rx_parser:
// raw input byte/valid plus the parser's registered, annotated copy.
interface eth_rx_parser_if #(
    parameter int unsigned pDATA_WIDTH        = 8,
    parameter int unsigned pMAX_PACKET_LENGHT = 1536
);
    localparam int unsigned CNT_W = $clog2(pMAX_PACKET_LENGHT + 1);

    logic                   i_dv;
    logic [pDATA_WIDTH-1:0] irx_d;
    logic [2:0]             o_state;
    logic [pDATA_WIDTH-1:0] o_rx_d;
    logic                   o_dv;
    logic [CNT_W-1:0]       o_byte_cnt;
    logic                   o_frame_done;
    logic                   o_frame_ok;
    logic [1:0]             o_err;

    modport master (
        output i_dv, irx_d,
        input  o_state, o_rx_d, o_dv, o_byte_cnt, o_frame_done, o_frame_ok, o_err
    );

    modport slave (
        input  i_dv, irx_d,
        output o_state, o_rx_d, o_dv, o_byte_cnt, o_frame_done, o_frame_ok, o_err
    );
endinterface

// File: rtl/eth_rx_parser.sv
// Receive frame parser: tags each byte with its frame-state code and byte index,
// and issues a one-cycle END verdict (length and CRC-32 residue check).
module eth_rx_parser #(
    parameter int unsigned pDATA_WIDTH        = 8,
    parameter int unsigned pMAX_PACKET_LENGHT = 1536,
    parameter int unsigned pMIN_FRAME         = 64,
    parameter int unsigned pMIN_PREAMBLE      = 2
) (
    input logic            iclk,
    input logic            irst,
    eth_rx_parser_if.slave bus
);
    localparam int unsigned      CNT_W       = $clog2(pMAX_PACKET_LENGHT + 1);
    localparam logic [CNT_W-1:0] MAX_IDX     = CNT_W'(pMAX_PACKET_LENGHT);
    localparam logic [CNT_W-1:0] RUNT_LAST   = CNT_W'(pMIN_FRAME - 1);
    localparam logic [2:0]       MIN_PRE     = 3'(pMIN_PREAMBLE);
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [pDATA_WIDTH-1:0] PRE_BYTE = pDATA_WIDTH'(8'h55);
    localparam logic [pDATA_WIDTH-1:0] SFD_BYTE = pDATA_WIDTH'(8'hD5);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PRE  = 3'b001,
        ST_DST  = 3'b010,
        ST_SRC  = 3'b011,
        ST_TYPE = 3'b100,
        ST_PAY  = 3'b101,
        ST_DROP = 3'b110,
        ST_END  = 3'b111
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_pre_cnt;
    logic                   r_sfd;
    logic [31:0]            r_crc;
    logic [1:0]             r_err_lat;
    logic [CNT_W-1:0]       r_byte_cnt;
    logic [pDATA_WIDTH-1:0] r_rx_d;
    logic                   r_dv;
    logic                   r_frame_ok;
    logic [1:0]             r_err;

    state_t           w_state;
    logic [2:0]       w_pre_cnt;
    logic             w_sfd;
    logic [31:0]      w_crc;
    logic [31:0]      w_crc_upd;
    logic [1:0]       w_err_lat;
    logic [CNT_W-1:0] w_byte_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_frame_ok;
    logic [1:0]       w_err;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [pDATA_WIDTH-1:0] d);
        logic [31:0] x;
        x = c ^ {{(32 - pDATA_WIDTH){1'b0}}, d};
        for (int unsigned i = 0; i < pDATA_WIDTH; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    function automatic state_t region(input logic [CNT_W-1:0] idx);
        if (idx < CNT_W'(6))
            return ST_DST;
        else if (idx < CNT_W'(12))
            return ST_SRC;
        else if (idx < CNT_W'(14))
            return ST_TYPE;
        else
            return ST_PAY;
    endfunction

    assign w_crc_upd = crc32_byte(r_crc, bus.irx_d);
    assign w_cnt_inc = r_byte_cnt + CNT_W'(1);

    always_comb begin
        w_state    = r_state;
        w_pre_cnt  = r_pre_cnt;
        w_sfd      = 1'b0;
        w_crc      = r_crc;
        w_err_lat  = r_err_lat;
        w_byte_cnt = '0;
        w_frame_ok = 1'b0;
        w_err      = '0;

        case (r_state)
            // END lasts one cycle and its successor byte is judged like IDLE
            ST_IDLE, ST_END: begin
                w_err_lat = '0;
                w_pre_cnt = '0;
                if (!bus.i_dv) begin
                    w_state = ST_IDLE;
                end else if (bus.irx_d == PRE_BYTE) begin
                    w_state   = ST_PRE;
                    w_pre_cnt = 3'd1;
                end else begin
                    w_state   = ST_DROP;
                    w_err_lat = 2'b01;
                end
            end

            // r_sfd marks that the SFD byte has just been shown with state PRE
            ST_PRE: begin
                if (!bus.i_dv) begin
                    w_state   = ST_IDLE;
                    w_pre_cnt = '0;
                end else if (r_sfd) begin
                    w_state    = ST_DST;
                    w_byte_cnt = '0;
                    w_crc      = w_crc_upd;
                end else if (bus.irx_d == PRE_BYTE) begin
                    if (r_pre_cnt != 3'd7)
                        w_pre_cnt = r_pre_cnt + 3'd1;
                end else if (bus.irx_d == SFD_BYTE && r_pre_cnt >= MIN_PRE) begin
                    w_sfd = 1'b1;
                    w_crc = '1;
                end else begin
                    w_state   = ST_DROP;
                    w_err_lat = 2'b01;
                end
            end

            ST_DST, ST_SRC, ST_TYPE, ST_PAY: begin
                if (!bus.i_dv) begin
                    w_state = ST_END;
                    if (r_state != ST_PAY || r_byte_cnt < RUNT_LAST)
                        w_err = 2'b01;
                    else if (r_crc != CRC_RESIDUE)
                        w_err = 2'b11;
                    else
                        w_frame_ok = 1'b1;
                end else if (w_cnt_inc == MAX_IDX) begin
                    w_state    = ST_DROP;
                    w_err_lat  = 2'b10;
                    w_byte_cnt = MAX_IDX;
                end else begin
                    w_state    = region(w_cnt_inc);
                    w_byte_cnt = w_cnt_inc;
                    w_crc      = w_crc_upd;
                end
            end

            ST_DROP: begin
                w_byte_cnt = r_byte_cnt;
                if (!bus.i_dv) begin
                    w_state    = ST_END;
                    w_err      = r_err_lat;
                    w_byte_cnt = '0;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= '0;
            r_sfd      <= 1'b0;
            r_crc      <= '1;
            r_err_lat  <= '0;
            r_byte_cnt <= '0;
            r_rx_d     <= '0;
            r_dv       <= 1'b0;
            r_frame_ok <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state;
            r_pre_cnt  <= w_pre_cnt;
            r_sfd      <= w_sfd;
            r_crc      <= w_crc;
            r_err_lat  <= w_err_lat;
            r_byte_cnt <= w_byte_cnt;
            r_rx_d     <= bus.irx_d;
            r_dv       <= bus.i_dv;
            r_frame_ok <= w_frame_ok;
            r_err      <= w_err;
        end
    end

    assign bus.o_state      = r_state;
    assign bus.o_rx_d       = r_rx_d;
    assign bus.o_dv         = r_dv;
    assign bus.o_byte_cnt   = r_byte_cnt;
    assign bus.o_frame_done = (r_state == ST_END);
    assign bus.o_frame_ok   = r_frame_ok;
    assign bus.o_err        = r_err;
endmodule

// File: doc/eth_rx_parser.md
# eth_rx_parser

Receive-side frame parser that sits directly upstream of the MAC learning memory. It consumes the raw per-port byte stream (`i_dv`/`irx_d`) and tracks frame structure through preamble, SFD, destination MAC, source MAC, length/type, payload and end-of-frame. It emits a registered, byte-aligned copy of the stream plus a 3-bit frame-state code, a byte index and a CRC-32/length verdict. The learning memory and forwarding logic key their field capture off the state code.

## Interface

- `pDATA_WIDTH`, 8, byte width; fixed at 8, other values unsupported.
- `pMAX_PACKET_LENGHT`, 1536, maximum frame bytes counted from the first DST byte, FCS included.
- `pMIN_FRAME`, 64, minimum valid frame bytes, FCS included.
- `pMIN_PREAMBLE`, 2, minimum count of 0x55 bytes required before the SFD.
- `iclk`  in  1  clock; single clock domain.
- `irst`  in  1  reset; synchronous, active-high.
- `i_dv`  in  1  input byte valid; high for the whole frame, preamble included.
- `irx_d`  in  8  input byte.
- `o_state`  out  3  frame-state code of the byte currently on `o_rx_d`.
- `o_rx_d`  out  8  registered copy of `irx_d`.
- `o_dv`  out  1  registered copy of `i_dv`.
- `o_byte_cnt`  out  $clog2(pMAX_PACKET_LENGHT+1)  index of the current byte from the first DST byte (0).
- `o_frame_done`  out  1  one-cycle pulse, coincident with `o_state`=111.
- `o_frame_ok`  out  1  valid only while `o_frame_done` is high: length and CRC both good.
- `o_err`  out  2  valid only while `o_frame_done` is high: 00 none, 01 malformed/runt, 10 oversize, 11 CRC error.

## Operation

- State codes: 000 IDLE, 001 PREAMBLE, 010 DST (bytes 0–5), 011 SRC (bytes 6–11), 100 TYPE (bytes 12–13), 101 PAYLOAD (byte 14 onward), 110 DROP, 111 END.
- IDLE
  - `i_dv`=1 with 0x55 → PREAMBLE.
  - `i_dv`=1 with any other byte → DROP, err 01.
  - `i_dv`=0 → stay in IDLE.
- PREAMBLE
  - 0x55 → increment the preamble count, saturating at 7.
  - 0xD5 with count ≥ `pMIN_PREAMBLE` → the next byte is DST.
  - 0xD5 with a short count, or any other byte → DROP, err 01.
  - `i_dv`=0 → IDLE, with no END cycle.
- DST, SRC, TYPE, PAYLOAD
  - Each byte advances `o_byte_cnt`; the state changes after byte 5, byte 11 and byte 13.
- `i_dv` falling during DST, SRC or TYPE → END, err 01.
- `i_dv` falling during PAYLOAD → END, with the verdict chosen in this order:
  - total bytes < `pMIN_FRAME` → err 01;
  - otherwise, CRC residue ≠ 0xDEBB20E3 → err 11;
  - otherwise → `o_frame_ok`=1, err 00.
- Oversize: the byte whose index equals `pMAX_PACKET_LENGHT` is output with state DROP, err 10. `o_byte_cnt` then holds at `pMAX_PACKET_LENGHT`.
- DROP: remain until `i_dv`=0, then END carrying the latched error.
- END: always exactly one cycle.
  - The byte sampled on the next edge is evaluated with IDLE rules, so 0x55 goes straight to PREAMBLE and no byte is lost.
- CRC
  - Reflected CRC-32, polynomial 0xEDB88320, 8-bit parallel update.
  - Register set to 0xFFFFFFFF at the SFD byte.
  - Updated on every byte from DST byte 0 through the last byte, FCS included.
  - At end of frame, compare the raw register (not inverted) with 0xDEBB20E3.
- Reset
  - State IDLE; all outputs 0; preamble count 0; CRC register 0xFFFFFFFF; latched error 00.
  - Reset asserted mid-frame abandons the frame with no END cycle.
  - After release, bytes of a frame still in progress are treated with IDLE rules (non-0x55 → DROP, err 01).

## Timing

- Every output is registered with one cycle of latency: the byte sampled at edge k appears on `o_rx_d`/`o_state` after edge k.
- The SFD byte is output with state 001. The first DST byte is output with state 010 and `o_byte_cnt`=0.
- END is produced by the edge that samples `i_dv`=0: `o_dv`=0, `o_state`=111, `o_frame_done`=1, and `o_err`/`o_frame_ok` are valid in the same cycle.
- `o_frame_ok` and `o_err` read 0 in every cycle other than END.
- `o_byte_cnt` resets to 0 in IDLE, PREAMBLE and END.
- Throughput is one byte per clock, with no back-pressure.
- The minimum inter-frame gap is one `i_dv`=0 cycle.

## Test plan

- Valid frame: 0x55×7, 0xD5, 60 data bytes, correct FCS → states 001/010/011/100/101. `o_byte_cnt` reaches 63, then END with `o_frame_ok`=1, err 00.
- Same frame with one payload bit flipped → END, `o_frame_ok`=0, err 11.
- Runt: 0x55×7, 0xD5, 10 bytes, then `i_dv` low → END while the last byte was in SRC, err 01.
- Oversize: 1540-byte frame after the SFD → byte index 1536 is output with state 110. `o_byte_cnt` holds at 1536, then END with err 10.
- Bad preamble: 0x55, 0xD5 with `pMIN_PREAMBLE`=2 → DROP, then END with err 01. A 0x55 byte followed by `i_dv` low → IDLE with no END.
- Back-to-back: two valid frames separated by a one-cycle gap → two END pulses, both ok. Reset asserted mid-PAYLOAD → next cycle all outputs 0, state 000, no `o_frame_done` pulse.
